player_input_cond: RTL

//  Conditions raw player inputs (mouse L/R buttons, GPIO L/R pins, pressure button) before the player-movement FSM.
//  Per channel: 2-FF synchronizer and counter debouncer.
//  Per player: left/right conflict resolution.

---
 rtl/player_input_cond.sv | 86 ++++++++
 1 files changed

// File: rtl/player_input_cond.sv
// Player input conditioning: per-channel 2-FF sync + counter debounce, per-player L/R conflict
// resolution, button rising-edge pulse. Define INPUT_BUTTON_TOGGLE_EN for a toggling button_pressed.
module player_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m_left_raw,
  input  logic m_right_raw,
  input  logic gpio_left_raw,
  input  logic gpio_right_raw,
  input  logic button_raw,
  output logic m_left,
  output logic m_right,
  output logic gpio_left,
  output logic gpio_right,
  output logic button_pressed,
  output logic button_edge
);

  localparam int unsigned NCH     = 5;
  localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CH_ML   = 0;
  localparam int unsigned CH_MR   = 1;
  localparam int unsigned CH_GL   = 2;
  localparam int unsigned CH_GR   = 3;
  localparam int unsigned CH_BTN  = 4;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] stable;
  logic [CW-1:0]  cnt [NCH];
  logic           btn_q;

  assign raw = {button_raw, gpio_right_raw, gpio_left_raw, m_right_raw, m_left_raw};

  // Synchronizer and debounce: stable flips after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < int'(NCH); i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < int'(NCH); i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Registered outputs; simultaneous left+right requests from one player cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_left         <= 1'b0;
      m_right        <= 1'b0;
      gpio_left      <= 1'b0;
      gpio_right     <= 1'b0;
      button_pressed <= 1'b0;
      button_edge    <= 1'b0;
      btn_q          <= 1'b0;
    end else begin
      m_left      <= stable[CH_ML] & ~stable[CH_MR];
      m_right     <= stable[CH_MR] & ~stable[CH_ML];
      gpio_left   <= stable[CH_GL] & ~stable[CH_GR];
      gpio_right  <= stable[CH_GR] & ~stable[CH_GL];
      btn_q       <= stable[CH_BTN];
      button_edge <= stable[CH_BTN] & ~btn_q;
`ifdef INPUT_BUTTON_TOGGLE_EN
      button_pressed <= button_pressed ^ (stable[CH_BTN] & ~btn_q);
`else
      button_pressed <= stable[CH_BTN];
`endif
    end
  end

endmodule
